alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline register that drives the SIMD ALU's operand and control inputs (ra, rb, ex_alu_ctrl, alu_imme, ex2alu_regwrite). It is the producer end of the ALU's input interface.
- Splits the 32-bit instruction into fields, selects operands through a forwarding mux (EX result > WB result > register file), and registers them with stall/flush control.
- While stalled, it refreshes held operands from a matching WB write so they never go stale.
- Sits between the decode stage / register file read ports and the ALU in the pipelined datapath.

Parameters:
DATA_WIDTH, 64, operand width
REG_ADDR_W, 5, register index width (32 registers)
ALU_OPCODE, 6'b101010, primary opcode of register-register/immediate ALU instructions

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high reset
id_vld  in  1  valid instruction presented by decode
id_instr  in  [0:31]  fields: opcode[0:5], rD[6:10], rA[11:15], rB[16:20], ww[24:25], func[26:31]
rf_addr_a  out  [0:4]  combinational = id_instr[11:15]
rf_addr_b  out  [0:4]  combinational = id_instr[16:20]
rf_data_a  in  [0:DATA_WIDTH-1]  register file read data for rf_addr_a (same cycle)
rf_data_b  in  [0:DATA_WIDTH-1]  register file read data for rf_addr_b
ex_fwd_data  in  [0:DATA_WIDTH-1]  current ALU result (alu_out)
ex_fwd_we  in  1  ALU result will be written back (alu2wb_regwirte)
ex_fwd_rd  in  [0:4]  destination of the instruction currently in EX
wb_data  in  [0:DATA_WIDTH-1]  data being written to the register file this cycle
wb_we  in  1  register file write enable this cycle
wb_rd  in  [0:4]  register file write address this cycle
stall  in  1  hold the ID/EX register
flush  in  1  insert a bubble
id_ready  out  1  = ~stall; decode may advance
ra  out  [0:DATA_WIDTH-1]  registered operand A
rb  out  [0:DATA_WIDTH-1]  registered operand B
ex_alu_ctrl  out  [0:13]  registered {opcode, ww, func}
alu_imme  out  [0:4]  registered id_instr[16:20]
ex2alu_regwrite  out  1  registered write intent
ex_rd  out  [0:4]  registered destination; also fed back as ex_fwd_rd
ex_vld  out  1  ID/EX register holds a live instruction

Behaviour:
- Reset (synchronous, active-high):
  - All registered outputs go to 0: ra, rb, ex_alu_ctrl, alu_imme, ex2alu_regwrite, ex_rd, ex_vld.
  - ex_alu_ctrl = 0 decodes to func 000000, but regwrite = 0, so no architectural effect.
- Operand select, evaluated separately for A (rA) and B (rB):
  - If ex_vld && ex_fwd_we && ex_fwd_rd == rX, take ex_fwd_data.
  - Else if wb_we && wb_rd == rX, take wb_data.
  - Else take rf_data_x.
  - Register 0 is general purpose; there is no hardwired zero.
- Write intent: id_regwrite = id_vld && (opcode == ALU_OPCODE). Other opcodes pass their fields through with regwrite = 0.
- Per-edge priority: reset > flush > stall > load.
  - flush (with or without stall): ex_vld = 0, ex2alu_regwrite = 0, ex_rd = 0. Operand and control registers keep their values.
  - stall && !flush: hold all fields. Exception: if ex_vld && wb_we && wb_rd == the held source of A (or B), reload that operand with wb_data.
    - Source register indices are stored internally as src_a and src_b (5 bits each).
    - EX forwarding is not applied during a stall. The held instruction is in EX, so it cannot be its own producer.
  - Load: capture the selected operands, {opcode, ww, func}, rB as alu_imme, id_regwrite, rD, src_a, src_b.
    - ex_vld = id_vld. When id_vld = 0, ex2alu_regwrite = 0.
- Latency: exactly 1 cycle from id_instr to ex_* outputs. There is no combinational path from id_* to ra/rb/ex_*.
- id_ready = ~stall, combinational. Flush does not deassert id_ready.
- A stall lasts any number of cycles. Back-to-back flushes leave ex_vld = 0.

Test Plan:
- Reset mid-stream: load ALU instr, assert reset on the next edge -> all outputs 0 in the following cycle, ex_vld = 0.
- Plain issue: rf_data_a = 64'h0102030405060708, rf_data_b = 64'h1, instr {101010, rD=3, rA=1, rB=2, ww=00, func=000101}, no forwarding -> one cycle later ra/rb match, ex_alu_ctrl = 14'b101010_00_000101, ex2alu_regwrite = 1, ex_rd = 3.
- Forward priority: rA = 5, with ex_fwd (we=1, rd=5, data=64'hAA) and wb (we=1, rd=5, data=64'hBB) both matching, rf = 64'hCC -> ra = 64'hAA; with ex_fwd_we = 0 -> ra = 64'hBB.
- Stall refresh: stall with src_a = 7 held and ra = 64'h10, then wb_we = 1, wb_rd = 7, wb_data = 64'h99 -> ra = 64'h99 next cycle, all other fields unchanged, id_ready = 0.
- Flush during stall: stall = 1 and flush = 1 -> ex_vld = 0, ex2alu_regwrite = 0; releasing stall loads the next instruction normally.
- Non-ALU opcode 6'b000001 with id_vld = 1 -> ex_vld = 1, ex2alu_regwrite = 0, fields passed through, alu_imme = rB field.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Bundle between decode / register file / writeback and the ALU issue stage.
// The stage itself uses the slave view; its environment uses the master view.
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  id_vld;
  logic [0:31]           id_instr;
  logic [0:REG_ADDR_W-1] rf_addr_a;
  logic [0:REG_ADDR_W-1] rf_addr_b;
  logic [0:DATA_WIDTH-1] rf_data_a;
  logic [0:DATA_WIDTH-1] rf_data_b;
  logic [0:DATA_WIDTH-1] ex_fwd_data;
  logic                  ex_fwd_we;
  logic [0:REG_ADDR_W-1] ex_fwd_rd;
  logic [0:DATA_WIDTH-1] wb_data;
  logic                  wb_we;
  logic [0:REG_ADDR_W-1] wb_rd;
  logic                  stall;
  logic                  flush;
  logic                  id_ready;
  logic [0:DATA_WIDTH-1] ra;
  logic [0:DATA_WIDTH-1] rb;
  logic [0:13]           ex_alu_ctrl;
  logic [0:REG_ADDR_W-1] alu_imme;
  logic                  ex2alu_regwrite;
  logic [0:REG_ADDR_W-1] ex_rd;
  logic                  ex_vld;

  modport master (
    output id_vld, id_instr, rf_data_a, rf_data_b, ex_fwd_data, ex_fwd_we, ex_fwd_rd,
           wb_data, wb_we, wb_rd, stall, flush,
    input  rf_addr_a, rf_addr_b, id_ready, ra, rb, ex_alu_ctrl, alu_imme,
           ex2alu_regwrite, ex_rd, ex_vld
  );

  modport slave (
    input  id_vld, id_instr, rf_data_a, rf_data_b, ex_fwd_data, ex_fwd_we, ex_fwd_rd,
           wb_data, wb_we, wb_rd, stall, flush,
    output rf_addr_a, rf_addr_b, id_ready, ra, rb, ex_alu_ctrl, alu_imme,
           ex2alu_regwrite, ex_rd, ex_vld
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the SIMD ALU: per-operand forwarding (EX > WB > RF),
// stall/flush control, and WB refresh of held operands while stalled.
module alu_issue_stage #(
  parameter int         DATA_WIDTH = 64,
  parameter int         REG_ADDR_W = 5,
  parameter logic [0:5] ALU_OPCODE = 6'b101010
) (
  input logic              clk,
  input logic              reset,
  alu_issue_stage_if.slave bus
);
  logic [0:5]            id_opcode;
  logic [0:5]            id_func;
  logic [0:1]            id_ww;
  logic [0:REG_ADDR_W-1] id_rd;
  logic [0:REG_ADDR_W-1] id_ra;
  logic [0:REG_ADDR_W-1] id_rb;
  logic                  id_regwrite;
  logic                  unused_instr_bits;

  assign id_opcode         = bus.id_instr[0:5];
  assign id_rd             = bus.id_instr[6:10];
  assign id_ra             = bus.id_instr[11:15];
  assign id_rb             = bus.id_instr[16:20];
  assign id_ww             = bus.id_instr[24:25];
  assign id_func           = bus.id_instr[26:31];
  assign unused_instr_bits = ^bus.id_instr[21:23];
  assign id_regwrite       = bus.id_vld && (id_opcode == ALU_OPCODE);

  assign bus.rf_addr_a = id_ra;
  assign bus.rf_addr_b = id_rb;
  assign bus.id_ready  = ~bus.stall;

  logic [0:13]           ctrl_q, ctrl_d;
  logic [0:REG_ADDR_W-1] imme_q, imme_d;
  logic [0:REG_ADDR_W-1] rd_q, rd_d;
  logic                  regwrite_q, regwrite_d;
  logic                  vld_q, vld_d;

  // Flush only kills the live/write bits; operand and control payload is left as-is.
  always_comb begin
    ctrl_d     = ctrl_q;
    imme_d     = imme_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    vld_d      = vld_q;
    if (bus.flush) begin
      vld_d      = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
    end else if (!bus.stall) begin
      ctrl_d     = {id_opcode, id_ww, id_func};
      imme_d     = id_rb;
      rd_d       = id_rd;
      regwrite_d = id_regwrite;
      vld_d      = bus.id_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      imme_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      imme_q     <= imme_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.ex_alu_ctrl     = ctrl_q;
  assign bus.alu_imme        = imme_q;
  assign bus.ex_rd           = rd_q;
  assign bus.ex2alu_regwrite = regwrite_q;
  assign bus.ex_vld          = vld_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opr
      logic [0:DATA_WIDTH-1] rf_rd;
      logic [0:DATA_WIDTH-1] opr_sel;
      logic [0:DATA_WIDTH-1] opr_q, opr_d;
      logic [0:REG_ADDR_W-1] id_src;
      logic [0:REG_ADDR_W-1] src_q, src_d;

      if (gi == 0) begin : g_a
        assign rf_rd  = bus.rf_data_a;
        assign id_src = id_ra;
        assign bus.ra = opr_q;
      end else begin : g_b
        assign rf_rd  = bus.rf_data_b;
        assign id_src = id_rb;
        assign bus.rb = opr_q;
      end

      always_comb begin
        opr_sel = rf_rd;
        if (vld_q && bus.ex_fwd_we && (bus.ex_fwd_rd == id_src)) begin
          opr_sel = bus.ex_fwd_data;
        end else if (bus.wb_we && (bus.wb_rd == id_src)) begin
          opr_sel = bus.wb_data;
        end
      end

      // While stalled the held instruction is in EX, so only a WB write can refresh it.
      always_comb begin
        opr_d = opr_q;
        src_d = src_q;
        if (bus.flush) begin
          opr_d = opr_q;
        end else if (bus.stall) begin
          if (vld_q && bus.wb_we && (bus.wb_rd == src_q)) begin
            opr_d = bus.wb_data;
          end
        end else begin
          opr_d = opr_sel;
          src_d = id_src;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          opr_q <= '0;
          src_q <= '0;
        end else begin
          opr_q <= opr_d;
          src_q <= src_d;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_alu_issue_stage;
  localparam logic [5:0] ALU_OP = 6'b101010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        prime;
    logic        vld;
    logic [31:0] instr;
    logic [63:0] rfa, rfb;
    logic        fwe;
    logic [4:0]  frd;
    logic [63:0] fdata;
    logic        wwe;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic [63:0] ea, eb;
    logic [13:0] ectrl;
    logic [4:0]  eimm;
    logic        erw;
    logic [4:0]  erd;
    logic        evld;
  } vec_t;

  vec_t vecs[8];

  typedef struct {
    logic        vld, rw;
    logic [4:0]  rd, imm, sa, sb;
    logic [13:0] ctrl;
    logic [63:0] a, b;
  } model_t;

  model_t m;

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rd, logic [4:0] ra,
                                     logic [4:0] rb, logic [1:0] ww, logic [5:0] fn);
    return {op, rd, ra, rb, 3'b000, ww, fn};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_vld      = 1'b0;
    bus.id_instr    = '0;
    bus.rf_data_a   = '0;
    bus.rf_data_b   = '0;
    bus.ex_fwd_data = '0;
    bus.ex_fwd_we   = 1'b0;
    bus.ex_fwd_rd   = '0;
    bus.wb_data     = '0;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic chk_out(string tag, logic [63:0] a, logic [63:0] b, logic [13:0] ctrl,
                         logic [4:0] imm, logic rw, logic [4:0] rd, logic vld);
    chk({tag, ".ra"}, bus.ra, a);
    chk({tag, ".rb"}, bus.rb, b);
    chk({tag, ".ctrl"}, 64'(bus.ex_alu_ctrl), 64'(ctrl));
    chk({tag, ".imme"}, 64'(bus.alu_imme), 64'(imm));
    chk({tag, ".regwrite"}, 64'(bus.ex2alu_regwrite), 64'(rw));
    chk({tag, ".ex_rd"}, 64'(bus.ex_rd), 64'(rd));
    chk({tag, ".ex_vld"}, 64'(bus.ex_vld), 64'(vld));
  endtask

  task automatic set_vec(int i, string name, logic prime, logic vld, logic [31:0] instr,
                         logic [63:0] rfa, logic [63:0] rfb,
                         logic fwe, logic [4:0] frd, logic [63:0] fdata,
                         logic wwe, logic [4:0] wrd, logic [63:0] wdata,
                         logic [63:0] ea, logic [63:0] eb, logic erw, logic evld);
    vecs[i].name  = name;   vecs[i].prime = prime; vecs[i].vld   = vld;
    vecs[i].instr = instr;  vecs[i].rfa   = rfa;   vecs[i].rfb   = rfb;
    vecs[i].fwe   = fwe;    vecs[i].frd   = frd;   vecs[i].fdata = fdata;
    vecs[i].wwe   = wwe;    vecs[i].wrd   = wrd;   vecs[i].wdata = wdata;
    vecs[i].ea    = ea;     vecs[i].eb    = eb;
    vecs[i].ectrl = {instr[31:26], instr[7:6], instr[5:0]};
    vecs[i].eimm  = instr[15:11];
    vecs[i].erw   = erw;
    vecs[i].erd   = instr[25:21];
    vecs[i].evld  = evld;
  endtask

  // Reference operand pick: EX result beats WB write beats register file.
  function automatic logic [63:0] pick(logic [4:0] src, logic [63:0] rfv, logic fwe,
                                       logic [4:0] frd, logic [63:0] fd, logic wwe,
                                       logic [4:0] wrd, logic [63:0] wd);
    if (m.vld && fwe && frd == src) return fd;
    if (wwe && wrd == src) return wd;
    return rfv;
  endfunction

  initial begin
    logic [4:0]  r_ra, r_rb, r_rd, r_frd, r_wrd;
    logic [5:0]  r_op, r_fn;
    logic [1:0]  r_ww;
    logic        r_vld, r_fwe, r_wwe, r_stall, r_flush, r_reset;
    logic [63:0] r_rfa, r_rfb, r_fd, r_wd, na, nb;

    idle();
    reset = 1'b1;
    step();
    step();
    chk_out("reset", 64'h0, 64'h0, 14'h0, 5'h0, 1'b0, 5'h0, 1'b0);
    reset = 1'b0;

    set_vec(0, "plain_issue", 1'b0, 1'b1, mk(ALU_OP, 5'd3, 5'd1, 5'd2, 2'b00, 6'b000101),
            64'h0102030405060708, 64'h1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
            64'h0102030405060708, 64'h1, 1'b1, 1'b1);
    set_vec(1, "fwd_ex_wins", 1'b1, 1'b1, mk(ALU_OP, 5'd9, 5'd5, 5'd6, 2'b01, 6'b000001),
            64'hCC, 64'hDD, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB,
            64'hAA, 64'hDD, 1'b1, 1'b1);
    set_vec(2, "fwd_wb_only", 1'b1, 1'b1, mk(ALU_OP, 5'd9, 5'd5, 5'd6, 2'b10, 6'b000010),
            64'hCC, 64'hDD, 1'b0, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB,
            64'hBB, 64'hDD, 1'b1, 1'b1);
    set_vec(3, "ex_fwd_needs_vld", 1'b0, 1'b1, mk(ALU_OP, 5'd9, 5'd5, 5'd6, 2'b11, 6'b000011),
            64'hCC, 64'hDD, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB,
            64'hBB, 64'hDD, 1'b1, 1'b1);
    set_vec(4, "non_alu_op", 1'b0, 1'b1, mk(6'b000001, 5'd7, 5'd4, 5'd17, 2'b01, 6'b110011),
            64'h1234, 64'h5678, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
            64'h1234, 64'h5678, 1'b0, 1'b1);
    set_vec(5, "id_not_valid", 1'b0, 1'b0, mk(ALU_OP, 5'd8, 5'd2, 5'd3, 2'b00, 6'b000100),
            64'h11, 64'h22, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
            64'h11, 64'h22, 1'b0, 1'b0);
    set_vec(6, "reg0_wb_fwd", 1'b0, 1'b1, mk(ALU_OP, 5'd1, 5'd0, 5'd0, 2'b00, 6'b001000),
            64'h33, 64'h44, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h77,
            64'h77, 64'h77, 1'b1, 1'b1);
    set_vec(7, "fwd_ex_on_b", 1'b1, 1'b1, mk(ALU_OP, 5'd2, 5'd10, 5'd11, 2'b10, 6'b010101),
            64'hF0, 64'hF1, 1'b1, 5'd11, 64'hDEADBEEF, 1'b1, 5'd10, 64'hF2,
            64'hF2, 64'hDEADBEEF, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      idle();
      if (vecs[i].prime) begin
        bus.id_vld   = 1'b1;
        bus.id_instr = mk(6'b000001, 5'd31, 5'd30, 5'd29, 2'b00, 6'b000000);
      end else begin
        bus.flush = 1'b1;
      end
      step();
      idle();
      bus.id_vld      = vecs[i].vld;
      bus.id_instr    = vecs[i].instr;
      bus.rf_data_a   = vecs[i].rfa;
      bus.rf_data_b   = vecs[i].rfb;
      bus.ex_fwd_we   = vecs[i].fwe;
      bus.ex_fwd_rd   = vecs[i].frd;
      bus.ex_fwd_data = vecs[i].fdata;
      bus.wb_we       = vecs[i].wwe;
      bus.wb_rd       = vecs[i].wrd;
      bus.wb_data     = vecs[i].wdata;
      #1;
      chk({vecs[i].name, ".rf_addr_a"}, 64'(bus.rf_addr_a), 64'(vecs[i].instr[20:16]));
      chk({vecs[i].name, ".rf_addr_b"}, 64'(bus.rf_addr_b), 64'(vecs[i].instr[15:11]));
      step();
      chk_out(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ectrl, vecs[i].eimm,
              vecs[i].erw, vecs[i].erd, vecs[i].evld);
      $display("vec %0d %s: ra=%h rb=%h ctrl=%b rw=%0b rd=%0d vld=%0b", i, vecs[i].name,
               bus.ra, bus.rb, bus.ex_alu_ctrl, bus.ex2alu_regwrite, bus.ex_rd, bus.ex_vld);
    end

    // Reset arriving right after an ALU instruction was loaded.
    idle();
    bus.id_vld    = 1'b1;
    bus.id_instr  = mk(ALU_OP, 5'd3, 5'd1, 5'd2, 2'b00, 6'b000101);
    bus.rf_data_a = 64'h5555;
    bus.rf_data_b = 64'h6666;
    step();
    reset = 1'b1;
    step();
    chk_out("reset_mid", 64'h0, 64'h0, 14'h0, 5'h0, 1'b0, 5'h0, 1'b0);
    $display("seq reset_mid: ex_vld=%0b ra=%h", bus.ex_vld, bus.ra);
    reset = 1'b0;

    // Stall with a WB write to the held source of A.
    idle();
    bus.id_vld    = 1'b1;
    bus.id_instr  = mk(ALU_OP, 5'd4, 5'd7, 5'd8, 2'b01, 6'b000011);
    bus.rf_data_a = 64'h10;
    bus.rf_data_b = 64'h20;
    step();
    chk("stall_pre.ra", bus.ra, 64'h10);
    bus.stall     = 1'b1;
    bus.wb_we     = 1'b1;
    bus.wb_rd     = 5'd7;
    bus.wb_data   = 64'h99;
    bus.id_instr  = mk(ALU_OP, 5'd9, 5'd9, 5'd9, 2'b11, 6'b111111);
    bus.rf_data_a = 64'hEE;
    bus.rf_data_b = 64'hEF;
    #1;
    chk("stall.id_ready", 64'(bus.id_ready), 64'h0);
    step();
    chk_out("stall_refresh", 64'h99, 64'h20, {ALU_OP, 2'b01, 6'b000011}, 5'd8, 1'b1, 5'd4, 1'b1);
    $display("seq stall_refresh: ra=%h rb=%h", bus.ra, bus.rb);
    bus.wb_we       = 1'b0;
    bus.ex_fwd_we   = 1'b1;
    bus.ex_fwd_rd   = 5'd7;
    bus.ex_fwd_data = 64'h55;
    step();
    chk("stall_no_ex_fwd.ra", bus.ra, 64'h99);
    $display("seq stall_no_ex_fwd: ra=%h", bus.ra);

    // Flush while stalled, a second flush alone, then normal load.
    bus.ex_fwd_we = 1'b0;
    bus.flush     = 1'b1;
    step();
    chk_out("flush_stall", 64'h99, 64'h20, {ALU_OP, 2'b01, 6'b000011}, 5'd8, 1'b0, 5'd0, 1'b0);
    bus.stall = 1'b0;
    #1;
    chk("flush.id_ready", 64'(bus.id_ready), 64'h1);
    step();
    chk("flush2.ex_vld", 64'(bus.ex_vld), 64'h0);
    bus.flush     = 1'b0;
    bus.id_instr  = mk(ALU_OP, 5'd12, 5'd1, 5'd2, 2'b10, 6'b111111);
    bus.rf_data_a = 64'hA1;
    bus.rf_data_b = 64'hB2;
    step();
    chk_out("after_flush", 64'hA1, 64'hB2, {ALU_OP, 2'b10, 6'b111111}, 5'd2, 1'b1, 5'd12, 1'b1);
    $display("seq flush_stall: ex_vld=%0b ex_rd=%0d", bus.ex_vld, bus.ex_rd);

    // Randomized traffic against the reference model.
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m = '{default: '0};
    for (int n = 0; n < 400; n++) begin
      r_vld   = ($urandom_range(0, 3) != 0);
      r_op    = ($urandom_range(0, 2) != 0) ? ALU_OP : 6'($urandom);
      r_rd    = 5'($urandom_range(0, 3));
      r_ra    = 5'($urandom_range(0, 3));
      r_rb    = 5'($urandom_range(0, 3));
      r_ww    = 2'($urandom);
      r_fn    = 6'($urandom);
      r_rfa   = {$urandom, $urandom};
      r_rfb   = {$urandom, $urandom};
      r_fwe   = $urandom_range(0, 1) == 1;
      r_frd   = 5'($urandom_range(0, 3));
      r_fd    = {$urandom, $urandom};
      r_wwe   = $urandom_range(0, 1) == 1;
      r_wrd   = 5'($urandom_range(0, 3));
      r_wd    = {$urandom, $urandom};
      r_stall = ($urandom_range(0, 9) < 3);
      r_flush = ($urandom_range(0, 9) == 0);
      r_reset = ($urandom_range(0, 49) == 0);

      bus.id_vld = r_vld;  bus.id_instr = mk(r_op, r_rd, r_ra, r_rb, r_ww, r_fn);
      bus.rf_data_a = r_rfa;  bus.rf_data_b = r_rfb;
      bus.ex_fwd_we = r_fwe;  bus.ex_fwd_rd = r_frd;  bus.ex_fwd_data = r_fd;
      bus.wb_we = r_wwe;  bus.wb_rd = r_wrd;  bus.wb_data = r_wd;
      bus.stall = r_stall;  bus.flush = r_flush;  reset = r_reset;
      #1;
      chk("rnd.rf_addr_a", 64'(bus.rf_addr_a), 64'(r_ra));
      chk("rnd.rf_addr_b", 64'(bus.rf_addr_b), 64'(r_rb));
      chk("rnd.id_ready", 64'(bus.id_ready), 64'(!r_stall));

      if (r_reset) begin
        m = '{default: '0};
      end else if (r_flush) begin
        m.vld = 1'b0;
        m.rw  = 1'b0;
        m.rd  = 5'd0;
      end else if (r_stall) begin
        if (m.vld && r_wwe && r_wrd == m.sa) m.a = r_wd;
        if (m.vld && r_wwe && r_wrd == m.sb) m.b = r_wd;
      end else begin
        na     = pick(r_ra, r_rfa, r_fwe, r_frd, r_fd, r_wwe, r_wrd, r_wd);
        nb     = pick(r_rb, r_rfb, r_fwe, r_frd, r_fd, r_wwe, r_wrd, r_wd);
        m.a    = na;
        m.b    = nb;
        m.sa   = r_ra;
        m.sb   = r_rb;
        m.ctrl = {r_op, r_ww, r_fn};
        m.imm  = r_rb;
        m.rd   = r_rd;
        m.rw   = r_vld && (r_op == ALU_OP);
        m.vld  = r_vld;
      end
      step();
      chk_out("rnd", m.a, m.b, m.ctrl, m.imm, m.rw, m.rd, m.vld);
      $display("rnd %0d: rst=%0b st=%0b fl=%0b ra=%h rb=%h vld=%0b rw=%0b", n, r_reset,
               r_stall, r_flush, bus.ra, bus.rb, bus.ex_vld, bus.ex2alu_regwrite);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
